// File: rtl/l1_dcache.sv
// l1_dcache: direct-mapped, write-through, no-write-allocate L1 data cache.
//
// Sits between the CPU MEM stage and main data memory. Read hits return data
// combinationally in the same cycle. Read misses stall the pipeline and fill a
// whole line, one word per request/ack beat. Stores are forwarded to memory
// and stall the pipeline until memory acknowledges. A store that hits also
// updates the cached word.
//
// Ports:
//   clock, reset        system clock, synchronous active-low reset
//   ren, wen            CPU load / store request (held stable while stall=1)
//   addr                CPU byte address
//   byte_select_vector  store byte enables (bit i = byte i)
//   din                 store data, already lane-aligned
//   dout                load data (combinational on hit, 0 otherwise)
//   stall               freeze pipeline
//   mem_ren, mem_wen    memory read-beat / write request
//   mem_addr            word-aligned memory byte address
//   mem_byte_en         memory write byte enables
//   mem_wdata           memory write data
//   mem_rdata, mem_ack  memory read data, valid with beat-complete ack
//   hit_count           completed read hits (wraps)
//   miss_count          read misses, one per fill (wraps)
module l1_dcache #(
   parameter int INDEX_BITS    = 6,
   parameter int WORD_OFF_BITS = 2,
   parameter int TAG_BITS      = 32 - INDEX_BITS - WORD_OFF_BITS - 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ren,
   input  logic        wen,
   input  logic [31:0] addr,
   input  logic [3:0]  byte_select_vector,
   input  logic [31:0] din,
   output logic [31:0] dout,
   output logic        stall,
   output logic        mem_ren,
   output logic        mem_wen,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_byte_en,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);

   localparam int LINES     = 1 << INDEX_BITS;
   localparam int WORDS     = 1 << WORD_OFF_BITS;
   localparam int SLOT_BITS = INDEX_BITS + WORD_OFF_BITS;

   typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

   state_t state, next_state;

   // Address split
   logic [WORD_OFF_BITS-1:0] word;
   logic [INDEX_BITS-1:0]    index;
   logic [TAG_BITS-1:0]      tag;

   assign word  = addr[WORD_OFF_BITS+1:2];
   assign index = addr[SLOT_BITS+1:WORD_OFF_BITS+2];
   assign tag   = addr[31:SLOT_BITS+2];

   // The byte offset only matters to the CPU's lane alignment, not to the cache.
   logic unused_byte_offset;
   assign unused_byte_offset = ^addr[1:0];

   // Storage
   logic [LINES-1:0]    valid;
   logic [TAG_BITS-1:0] tag_mem  [LINES];
   logic [31:0]         data_mem [LINES*WORDS];

   logic [WORD_OFF_BITS-1:0] beat;
   logic [31:0]              cached_word;
   logic [31:0]              merged_word;
   logic                     hit;
   logic                     last_beat;

   assign cached_word = data_mem[{index, word}];
   assign hit         = valid[index] && (tag_mem[index] == tag);
   assign last_beat   = &beat;

   // Cached word with the enabled store bytes substituted in.
   always_comb begin
      merged_word = cached_word;
      for (int b = 0; b < 4; b++) begin
         if (byte_select_vector[b]) merged_word[8*b +: 8] = din[8*b +: 8];
      end
   end

   // Next state and all outputs. While reset is low every output is held at 0.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // a signal unassigned, which would otherwise infer a latch.
      next_state  = state;
      stall       = 1'b0;
      dout        = '0;
      mem_ren     = 1'b0;
      mem_wen     = 1'b0;
      mem_addr    = '0;
      mem_byte_en = '0;
      mem_wdata   = '0;
      if (reset) begin
         case (state)
            IDLE: begin
               // Store wins if the CPU ever raises both requests.
               if (wen) begin
                  stall      = 1'b1;
                  next_state = WRITE;
               end else if (ren) begin
                  if (hit) begin
                     dout = cached_word;
                  end else begin
                     stall      = 1'b1;
                     next_state = FILL;
                  end
               end
            end
            FILL: begin
               // CPU address is frozen by the stall, so tag/index stay stable.
               stall    = 1'b1;
               mem_ren  = 1'b1;
               mem_addr = {tag, index, beat, 2'b00};
               if (mem_ack && last_beat) next_state = IDLE;
            end
            WRITE: begin
               mem_wen     = 1'b1;
               mem_addr    = {addr[31:2], 2'b00};
               mem_byte_en = byte_select_vector;
               mem_wdata   = din;
               // The CPU advances on the same edge that memory accepts the store.
               stall       = ~mem_ack;
               if (mem_ack) next_state = IDLE;
            end
            default: next_state = IDLE;
         endcase
      end
   end

   // Control state: FSM, valid bits, beat counter, statistics.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!reset) begin
         state      <= IDLE;
         valid      <= '0;
         beat       <= '0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         state <= next_state;
         case (state)
            IDLE: begin
               if (ren && !wen) begin
                  if (hit) begin
                     hit_count <= hit_count + 32'd1;
                  end else begin
                     miss_count   <= miss_count + 32'd1;
                     beat         <= '0;
                     // Line is invalid until its last beat lands, so an
                     // abandoned fill never leaves a half-written valid line.
                     valid[index] <= 1'b0;
                  end
               end
            end
            FILL: begin
               if (mem_ack) begin
                  beat <= beat + WORD_OFF_BITS'(1);
                  if (last_beat) valid[index] <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Tag and data arrays.
   always_ff @(posedge clock) begin
      // NOTE: the arrays are deliberately not reset; the valid bits alone
      // decide whether their contents mean anything.
      if (reset) begin
         if (state == FILL && mem_ack) begin
            data_mem[{index, beat}] <= mem_rdata;
            if (last_beat) tag_mem[index] <= tag;
         end
         // No-write-allocate: a store miss leaves the arrays untouched.
         if (state == WRITE && mem_ack && hit) data_mem[{index, word}] <= merged_word;
      end
   end

endmodule

// File: tb/tb_l1_dcache.sv
// tb_l1_dcache: self-checking bench for l1_dcache.
//
// The driver issues CPU loads/stores and, for each one, pushes the expected
// CPU-side completion into cpu_q and the expected memory-bus beats into bus_q.
// The reference model is a tag table per line plus a flat word memory: since
// the cache is write-through, the expected load data is always the current
// memory word. A CPU monitor and a memory responder pop and compare
// independently of the driver.
module tb_l1_dcache;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        ren = 1'b0;
   logic        wen = 1'b0;
   logic [31:0] addr = '0;
   logic [3:0]  byte_select_vector = '0;
   logic [31:0] din = '0;
   logic [31:0] dout;
   logic        stall;
   logic        mem_ren;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [3:0]  mem_byte_en;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   always #5 clock = ~clock;

   l1_dcache dut (
      .clock(clock), .reset(reset), .ren(ren), .wen(wen), .addr(addr),
      .byte_select_vector(byte_select_vector), .din(din), .dout(dout),
      .stall(stall), .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_byte_en(mem_byte_en), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
   );

   typedef struct {
      bit          is_load;
      logic [31:0] data;
      int          stall_cyc;
      int          hits;
      int          misses;
   } cpu_exp_t;

   typedef struct {
      bit          is_write;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
   } bus_exp_t;

   cpu_exp_t cpu_q[$];
   bus_exp_t bus_q[$];

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model
   logic [31:0] ref_mem  [logic [31:0]];
   logic [31:0] phys_mem [logic [31:0]];
   bit          ref_valid [64];
   logic [21:0] ref_tag   [64];
   int          model_hits   = 0;
   int          model_misses = 0;
   int          ack_delay    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5EED, ~a[15:0]};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
      logic [31:0] r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] wa);
      return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
   endfunction

   function automatic logic [31:0] phys_read(input logic [31:0] wa);
      return phys_mem.exists(wa) ? phys_mem[wa] : init_word(wa);
   endfunction

   task automatic set_mem(input logic [31:0] wa, input logic [31:0] v);
      ref_mem[wa]  = v;
      phys_mem[wa] = v;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 64; i++) ref_valid[i] = 1'b0;
      model_hits   = 0;
      model_misses = 0;
   endtask

   task automatic print_summary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
   endtask

   // Wait for the request to complete, then step to just after the edge.
   task automatic wait_done();
      int n = 0;
      do begin
         @(negedge clock);
         n++;
         if (n > 500) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout: stall=%b after %0d cycles, expected 0", stall, n);
            print_summary();
            $fatal(1, "request never completed");
         end
      end while (stall);
      @(posedge clock);
      #1;
   endtask

   task automatic cpu_load(input logic [31:0] a);
      cpu_exp_t    e;
      int          idx = int'((a >> 4) % 64);
      logic [21:0] t   = a[31:10];
      logic [31:0] base = {a[31:4], 4'h0};
      e.is_load = 1'b1;
      e.data    = ref_read({a[31:2], 2'b00});
      e.hits    = model_hits;
      if (ref_valid[idx] && ref_tag[idx] == t) begin
         e.stall_cyc = 0;
      end else begin
         model_misses++;
         e.stall_cyc    = 1 + 4 * (ack_delay + 1);
         ref_valid[idx] = 1'b1;
         ref_tag[idx]   = t;
         for (int b = 0; b < 4; b++) bus_q.push_back('{1'b0, base + 32'(4 * b), 4'h0, 32'h0});
      end
      e.misses = model_misses;
      model_hits++;
      cpu_q.push_back(e);
      ren  = 1'b1;
      wen  = 1'b0;
      addr = a;
      wait_done();
      ren = 1'b0;
   endtask

   task automatic cpu_store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      cpu_exp_t    e;
      logic [31:0] wa = {a[31:2], 2'b00};
      e.is_load   = 1'b0;
      e.data      = '0;
      e.stall_cyc = ack_delay + 1;
      e.hits      = model_hits;
      e.misses    = model_misses;
      bus_q.push_back('{1'b1, wa, be, d});
      ref_mem[wa] = merge(ref_read(wa), d, be);
      cpu_q.push_back(e);
      wen                = 1'b1;
      ren                = 1'b0;
      addr               = a;
      byte_select_vector = be;
      din                = d;
      wait_done();
      wen = 1'b0;
   endtask

   // CPU-side monitor: counts stall cycles and checks each completion.
   int       stall_run = 0;
   cpu_exp_t mon_e;
   always @(negedge clock) begin
      if (!reset) begin
         stall_run = 0;
      end else if (ren || wen) begin
         if (stall) begin
            stall_run++;
         end else begin
            if (cpu_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL cpu_unexpected: completion at %h, nothing expected", addr);
            end else begin
               mon_e = cpu_q.pop_front();
               if (mon_e.is_load) check("load_dout", dout, mon_e.data);
               check("stall_cycles", 32'(stall_run), 32'(mon_e.stall_cyc));
               check("hit_count", hit_count, 32'(mon_e.hits));
               check("miss_count", miss_count, 32'(mon_e.misses));
            end
            stall_run = 0;
         end
      end
   end

   // Memory responder: acks after ack_delay waiting cycles, checks each beat
   // against bus_q every cycle it is presented (so held values are checked too).
   int       wait_cnt = 0;
   bus_exp_t bus_e;
   always @(posedge clock) begin
      #2;
      if (mem_ack) wait_cnt = 0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      if (!reset) begin
         wait_cnt = 0;
      end else if (mem_ren || mem_wen) begin
         if (mem_ren && mem_wen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL bus_both: mem_ren and mem_wen both high at %h", mem_addr);
         end
         if (bus_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL bus_unexpected: ren=%b wen=%b addr %h, nothing expected",
                     mem_ren, mem_wen, mem_addr);
         end else begin
            bus_e = bus_q[0];
            check("bus_kind", 32'(mem_wen), 32'(bus_e.is_write));
            check("bus_addr", mem_addr, bus_e.addr);
            if (bus_e.is_write) begin
               check("bus_wdata", mem_wdata, bus_e.data);
               check("bus_be", 32'(mem_byte_en), 32'(bus_e.be));
            end
         end
         if (wait_cnt >= ack_delay) begin
            mem_ack = 1'b1;
            if (bus_q.size() != 0) void'(bus_q.pop_front());
            if (mem_ren) mem_rdata = phys_read(mem_addr);
            else phys_mem[mem_addr] = merge(phys_read(mem_addr), mem_wdata, mem_byte_en);
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
         check("bus_idle_addr", mem_addr, 32'h0);
         check("bus_idle_wdata", mem_wdata | 32'(mem_byte_en), 32'h0);
      end
   end

   initial begin
      #2_000_000;
      n_cmp++;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      print_summary();
      $fatal(1, "watchdog");
   end

   logic [31:0] ra;
   initial begin
      // Reset with a load request pending: outputs must stay quiet.
      reset = 1'b0;
      ren   = 1'b1;
      addr  = 32'h0000_0104;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_stall", 32'(stall), 32'h0);
      check("rst_dout", dout, 32'h0);
      check("rst_mem_req", 32'({mem_ren, mem_wen}), 32'h0);
      check("rst_hits", hit_count, 32'h0);
      check("rst_misses", miss_count, 32'h0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      ren   = 1'b0;
      model_reset();

      set_mem(32'h100, 32'hA0A0_A0A0);
      set_mem(32'h104, 32'hA1A1_A1A1);
      set_mem(32'h108, 32'hA2A2_A2A2);
      set_mem(32'h10C, 32'hA3A3_A3A3);

      // 1: cold miss, single-cycle ack fill, then the hit returns A1
      ack_delay = 0;
      cpu_load(32'h0000_0104);
      check("t1_hits", hit_count, 32'd1);
      // 2: hit in the filled line
      cpu_load(32'h0000_010C);
      check("t2_hits", hit_count, 32'd2);
      // 3: store hit with a slow ack, then read back the merged word
      ack_delay = 3;
      cpu_store(32'h0000_0108, 4'b0010, 32'h0000_AB00);
      ack_delay = 0;
      cpu_load(32'h0000_0108);
      check("t3_ref_merge", ref_read(32'h108), 32'hA2A2_ABA2);
      // 4: store miss does not allocate; the following load misses
      ack_delay = 1;
      cpu_store(32'h0000_2000, 4'hF, 32'hCAFE_F00D);
      cpu_load(32'h0000_2000);
      // 5: conflict eviction on index 0x10
      ack_delay = 0;
      cpu_load(32'h0000_0104);
      cpu_load(32'h0000_0504);
      cpu_load(32'h0000_0104);
      check("t5_misses", miss_count, 32'd4);

      // 6: reset in the middle of a fill, after two beats
      bus_q.push_back('{1'b0, 32'h500, 4'h0, 32'h0});
      bus_q.push_back('{1'b0, 32'h504, 4'h0, 32'h0});
      ren  = 1'b1;
      addr = 32'h0000_0504;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      check("t6_rst_stall", 32'(stall), 32'h0);
      check("t6_rst_mem_ren", 32'(mem_ren), 32'h0);
      check("t6_rst_dout", dout, 32'h0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      ren   = 1'b0;
      model_reset();
      @(negedge clock);
      check("t6_hits", hit_count, 32'h0);
      check("t6_misses", miss_count, 32'h0);
      check("t6_stall", 32'(stall), 32'h0);
      check("t6_mem_ren", 32'(mem_ren), 32'h0);
      check("t6_bus_q_drained", 32'(bus_q.size()), 32'h0);
      @(posedge clock);
      #1;
      cpu_load(32'h0000_0104);

      // Random mix over a few indices and tags to force hits and conflicts.
      for (int i = 0; i < 150; i++) begin
         ra = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 3)) << 4)
            | (32'($urandom_range(0, 3)) << 2);
         ack_delay = int'($urandom_range(0, 2));
         if ($urandom_range(0, 2) == 0)
            cpu_store(ra | 32'($urandom_range(0, 3)), 4'($urandom_range(1, 15)), $urandom());
         else
            cpu_load(ra);
      end

      repeat (4) @(posedge clock);
      @(negedge clock);
      check("end_cpu_q_empty", 32'(cpu_q.size()), 32'h0);
      check("end_bus_q_empty", 32'(bus_q.size()), 32'h0);
      check("end_hits", hit_count, 32'(model_hits));
      check("end_misses", miss_count, 32'(model_misses));
      print_summary();
      $finish;
   end

endmodule
